// File: rtl/exu_lsu_arb.sv
// Store buffer and load/store arbiter between the EXU and a single LSU port.
// Ports: clock/reset; flush_pipeline; st_* enqueue; cm_store commit;
//        ld_* load request/response; out_* LSU strobes; lsu_* LSU handshake;
//        sq_empty status.
module exu_lsu_arb #(
  parameter int XLEN     = 32,
  parameter int SQ_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipeline,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  input  logic [4:0]      st_alu_op,
  input  logic            cm_store,
  input  logic            ld_req,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [4:0]      ld_alu_op,
  output logic            ld_done,
  output logic [XLEN-1:0] ld_rdata,
  output logic            out_ren,
  output logic            out_wen,
  output logic [XLEN-1:0] out_rwaddr,
  output logic [4:0]      out_alu_op,
  output logic [XLEN-1:0] out_wdata,
  input  logic            lsu_rvalid,
  input  logic [XLEN-1:0] lsu_rdata,
  input  logic            lsu_wready,
  output logic            sq_empty
);

  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(SQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN
  } state_t;

  logic [XLEN-1:0]     sq_addr [SQ_DEPTH];
  logic [XLEN-1:0]     sq_data [SQ_DEPTH];
  logic [4:0]          sq_op   [SQ_DEPTH];
  logic [SQ_DEPTH-1:0] sq_cm;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] cm_ptr;
  logic [PW-1:0] cm_ptr_n;
  logic [CW-1:0] count;
  logic [CW-1:0] cm_count;
  logic [CW-1:0] cm_count_n;

  logic enq;
  logic cm_ok;
  logic pop;
  logic head_cm;
  logic ld_conflict;

  state_t          state;
  state_t          state_n;
  logic            out_ren_n;
  logic            out_wen_n;
  logic [XLEN-1:0] out_rwaddr_n;
  logic [4:0]      out_alu_op_n;
  logic [XLEN-1:0] out_wdata_n;
  logic            ld_done_n;
  logic [XLEN-1:0] ld_rdata_n;

  assign st_ready = count < FULL;
  assign sq_empty = count == '0;
  assign enq      = st_valid && st_ready && !flush_pipeline;
  // With a full buffer cm_ptr == tail still has an uncommitted entry.
  assign cm_ok    = cm_store && ((cm_ptr != tail) || (count == FULL));
  assign head_cm  = sq_cm[head] && (count != '0);

  // Committed-entry bookkeeping after this cycle's commit and pop;
  // a flush rolls tail/count back to exactly this point.
  assign cm_ptr_n   = cm_ptr + PW'(cm_ok);
  assign cm_count_n = cm_count + CW'(cm_ok) - CW'(pop);

  // A load may not bypass any buffered store to the same word.
  always_comb begin : conflict_b
    logic [PW-1:0] off;
    off         = '0;
    ld_conflict = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      off = PW'(i) - head;
      if (({1'b0, off} < count) &&
          (sq_addr[i][XLEN-1:2] == ld_addr[XLEN-1:2]))
        ld_conflict = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      sq_addr[tail] <= st_addr;
      sq_data[tail] <= st_data;
      sq_op[tail]   <= st_alu_op;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      cm_ptr   <= '0;
      count    <= '0;
      cm_count <= '0;
      sq_cm    <= '0;
    end else begin
      if (enq)
        sq_cm[tail] <= 1'b0;
      if (cm_ok)
        sq_cm[cm_ptr] <= 1'b1;
      if (pop) begin
        sq_cm[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      cm_ptr   <= cm_ptr_n;
      cm_count <= cm_count_n;
      if (flush_pipeline) begin
        tail  <= cm_ptr_n;
        count <= cm_count_n;
      end else begin
        tail  <= tail + PW'(enq);
        count <= count + CW'(enq) - CW'(pop);
      end
    end
  end

  always_comb begin
    state_n      = state;
    out_ren_n    = out_ren;
    out_wen_n    = out_wen;
    out_rwaddr_n = out_rwaddr;
    out_alu_op_n = out_alu_op;
    out_wdata_n  = out_wdata;
    ld_done_n    = 1'b0;
    ld_rdata_n   = ld_rdata;
    pop          = 1'b0;
    unique case (state)
      IDLE: begin
        if (head_cm) begin
          state_n      = STORE;
          out_wen_n    = 1'b1;
          out_rwaddr_n = sq_addr[head];
          out_wdata_n  = sq_data[head];
          out_alu_op_n = sq_op[head];
        end else if (ld_req && !ld_conflict && !flush_pipeline) begin
          state_n      = LOAD;
          out_ren_n    = 1'b1;
          out_rwaddr_n = ld_addr;
          out_alu_op_n = ld_alu_op;
        end
      end
      STORE: begin
        if (lsu_wready) begin
          state_n   = IDLE;
          out_wen_n = 1'b0;
          pop       = 1'b1;
        end
      end
      LOAD: begin
        if (lsu_rvalid) begin
          state_n   = IDLE;
          out_ren_n = 1'b0;
          if (!flush_pipeline) begin
            ld_done_n  = 1'b1;
            ld_rdata_n = lsu_rdata;
          end
        end else if (flush_pipeline) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (lsu_rvalid) begin
          state_n   = IDLE;
          out_ren_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      out_ren    <= 1'b0;
      out_wen    <= 1'b0;
      out_rwaddr <= '0;
      out_alu_op <= '0;
      out_wdata  <= '0;
      ld_done    <= 1'b0;
      ld_rdata   <= '0;
    end else begin
      state      <= state_n;
      out_ren    <= out_ren_n;
      out_wen    <= out_wen_n;
      out_rwaddr <= out_rwaddr_n;
      out_alu_op <= out_alu_op_n;
      out_wdata  <= out_wdata_n;
      ld_done    <= ld_done_n;
      ld_rdata   <= ld_rdata_n;
    end
  end

endmodule

// File: tb/tb_exu_lsu_arb.sv
// Scoreboard bench for exu_lsu_arb: LSU responder model, write/load
// monitors against expected queues, directed stimulus.
module tb_exu_lsu_arb;

  logic        clock;
  logic        reset;
  logic        flush_pipeline;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [4:0]  st_alu_op;
  logic        cm_store;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [4:0]  ld_alu_op;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        out_ren;
  logic        out_wen;
  logic [31:0] out_rwaddr;
  logic [4:0]  out_alu_op;
  logic [31:0] out_wdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_wready;
  logic        sq_empty;

  exu_lsu_arb #(.XLEN(32), .SQ_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush_pipeline (flush_pipeline),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .st_alu_op      (st_alu_op),
    .cm_store       (cm_store),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_alu_op      (ld_alu_op),
    .ld_done        (ld_done),
    .ld_rdata       (ld_rdata),
    .out_ren        (out_ren),
    .out_wen        (out_wen),
    .out_rwaddr     (out_rwaddr),
    .out_alu_op     (out_alu_op),
    .out_wdata      (out_wdata),
    .lsu_rvalid     (lsu_rvalid),
    .lsu_rdata      (lsu_rdata),
    .lsu_wready     (lsu_wready),
    .sq_empty       (sq_empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  op;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  logic [31:0] dq[$];

  int checks = 0;
  int errors = 0;
  int wdelay = 1;
  int rdelay = 1;
  bit whold  = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // sel: 0 buffer empty, 1 ld_done, 2 out_ren, 3 st_ready
  task automatic wait_for(input int sel, input string nm);
    bit ok;
    for (int i = 0; i < 60; i++) begin
      tick();
      case (sel)
        0: ok = sq_empty && !out_wen;
        1: ok = ld_done;
        2: ok = out_ren;
        default: ok = st_ready;
      endcase
      if (ok) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout got 0 expected 1", nm);
  endtask

  // LSU model: completes each strobe after a programmable number of cycles.
  initial begin : lsu_model
    int wcnt;
    int rcnt;
    wcnt = 0;
    rcnt = 0;
    lsu_wready = 0;
    lsu_rvalid = 0;
    lsu_rdata  = 0;
    forever begin
      @(negedge clock);
      lsu_wready = 0;
      lsu_rvalid = 0;
      if (out_wen && !reset && !whold) begin
        wcnt++;
        if (wcnt >= wdelay) begin
          lsu_wready = 1;
          wcnt = 0;
        end
      end else if (!out_wen) begin
        wcnt = 0;
      end
      if (out_ren && !reset) begin
        rcnt++;
        if (rcnt >= rdelay) begin
          lsu_rvalid = 1;
          lsu_rdata  = ~out_rwaddr;
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  initial begin : monitor
    bit   pw;
    bit   pr;
    wr_t  e;
    pw = 0;
    pr = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (out_wen && !pw) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%08h expected none",
                     out_rwaddr);
          end else begin
            e = wq.pop_front();
            chk("wr_addr", out_rwaddr, e.addr);
            chk("wr_data", out_wdata, e.data);
            chk("wr_op", 32'(out_alu_op), 32'(e.op));
          end
        end
        if (out_ren && !pr) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got addr 0x%08h expected none",
                     out_rwaddr);
          end else begin
            chk("rd_addr", out_rwaddr, rq.pop_front());
          end
        end
        if (ld_done) begin
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ld_done: got 0x%08h expected none",
                     ld_rdata);
          end else begin
            chk("ld_rdata", ld_rdata, dq.pop_front());
          end
        end
      end
      pw = out_wen;
      pr = out_ren;
    end
  end

  initial begin : stim
    bit seen;
    reset = 1;
    flush_pipeline = 0;
    st_valid = 0;
    st_addr = 0;
    st_data = 0;
    st_alu_op = 0;
    cm_store = 0;
    ld_req = 0;
    ld_addr = 0;
    ld_alu_op = 0;
    tick();
    reset = 0;
    chk("rst_st_ready", 32'(st_ready), 1);
    chk("rst_sq_empty", 32'(sq_empty), 1);
    chk("rst_out_ren", 32'(out_ren), 0);
    chk("rst_out_wen", 32'(out_wen), 0);
    chk("rst_ld_done", 32'(ld_done), 0);
    chk("rst_rwaddr", out_rwaddr, 0);

    // single store, commit next cycle
    wdelay = 1;
    wq.push_back('{32'h80000010, 32'hDEADBEEF, 5'd2});
    st_valid = 1;
    st_addr = 32'h80000010;
    st_data = 32'hDEADBEEF;
    st_alu_op = 5'd2;
    tick();
    st_valid = 0;
    cm_store = 1;
    chk("t2_not_empty", 32'(sq_empty), 0);
    tick();
    cm_store = 0;
    chk("t2_wen_before", 32'(out_wen), 0);
    tick();
    chk("t2_wen_latency", 32'(out_wen), 1);
    tick();
    chk("t2_empty", 32'(sq_empty), 1);
    chk("t2_wen_low", 32'(out_wen), 0);

    // fill, overflow attempt, wrap
    for (int i = 0; i < 4; i++) begin
      wq.push_back('{32'h80000100 + 32'(i * 4), 32'hA0 + 32'(i), 5'd2});
      st_valid = 1;
      st_addr = 32'h80000100 + 32'(i * 4);
      st_data = 32'hA0 + 32'(i);
      tick();
    end
    st_addr = 32'h80000200;
    st_data = 32'hBAD0BAD0;
    chk("t3_full", 32'(st_ready), 0);
    tick();
    st_valid = 0;
    chk("t3_still_full", 32'(st_ready), 0);
    wq.push_back('{32'h80000110, 32'hA4, 5'd2});
    cm_store = 1;
    tick();
    cm_store = 0;
    wait_for(3, "t3_ready");
    st_valid = 1;
    st_addr = 32'h80000110;
    st_data = 32'hA4;
    tick();
    st_valid = 0;
    chk("t3_refull", 32'(st_ready), 0);
    cm_store = 1;
    repeat (4) tick();
    cm_store = 0;
    wait_for(0, "t3_drain");
    chk("t3_empty", 32'(sq_empty), 1);

    // load address conflict
    rdelay = 2;
    st_valid = 1;
    st_addr = 32'h80000016;
    st_data = 32'h5555AAAA;
    tick();
    st_valid = 0;
    rq.push_back(32'h80000020);
    dq.push_back(32'h7FFFFFDF);
    ld_req = 1;
    ld_addr = 32'h80000020;
    ld_alu_op = 5'd10;
    tick();
    chk("t4_ren_nocf", 32'(out_ren), 1);
    wait_for(1, "t4_done_nocf");
    ld_req = 0;
    tick();
    rq.push_back(32'h80000014);
    dq.push_back(32'h7FFFFFEB);
    ld_req = 1;
    ld_addr = 32'h80000014;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_ren_conflict", 32'(out_ren), 0);
    end
    wq.push_back('{32'h80000016, 32'h5555AAAA, 5'd2});
    cm_store = 1;
    tick();
    cm_store = 0;
    wait_for(1, "t4_done_cf");
    ld_req = 0;
    chk("t4_empty_at_done", 32'(sq_empty), 1);

    // flush with 2 committed + 1 uncommitted
    whold = 1;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1;
      st_addr = 32'h80000300 + 32'(i * 4);
      st_data = 32'hB0 + 32'(i);
      tick();
    end
    st_valid = 0;
    wq.push_back('{32'h80000300, 32'hB0, 5'd2});
    wq.push_back('{32'h80000304, 32'hB1, 5'd2});
    cm_store = 1;
    repeat (2) tick();
    cm_store = 0;
    tick();
    flush_pipeline = 1;
    tick();
    flush_pipeline = 0;
    for (int i = 0; i < 2; i++) begin
      st_valid = 1;
      st_addr = 32'h80000400 + 32'(i * 4);
      st_data = 32'hC0 + 32'(i);
      tick();
    end
    st_valid = 0;
    chk("t5_count_after_flush", 32'(st_ready), 0);
    flush_pipeline = 1;
    tick();
    flush_pipeline = 0;
    chk("t5_reflush_ready", 32'(st_ready), 1);
    whold = 0;
    wait_for(0, "t5_drain");

    // flush during a load
    rdelay = 3;
    rq.push_back(32'h80000030);
    ld_req = 1;
    ld_addr = 32'h80000030;
    tick();
    chk("t5_ren", 32'(out_ren), 1);
    flush_pipeline = 1;
    ld_req = 0;
    tick();
    flush_pipeline = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | ld_done;
    end
    chk("t5_no_done", 32'(seen), 0);
    chk("t5_ren_low", 32'(out_ren), 0);

    // store wins over simultaneous load
    wdelay = 2;
    rdelay = 1;
    wq.push_back('{32'h80000050, 32'hE0E0E0E0, 5'd2});
    rq.push_back(32'h80000040);
    dq.push_back(32'h7FFFFFBF);
    st_valid = 1;
    st_addr = 32'h80000050;
    st_data = 32'hE0E0E0E0;
    tick();
    st_valid = 0;
    cm_store = 1;
    tick();
    cm_store = 0;
    ld_req = 1;
    ld_addr = 32'h80000040;
    tick();
    chk("t6_wen_first", 32'(out_wen), 1);
    chk("t6_ren_held", 32'(out_ren), 0);
    wait_for(2, "t6_ren");
    chk("t6_store_done", 32'(sq_empty), 1);
    wait_for(1, "t6_done");
    ld_req = 0;
    repeat (3) tick();

    chk("end_wq", 32'(wq.size()), 0);
    chk("end_rq", 32'(rq.size()), 0);
    chk("end_dq", 32'(dq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
